sdram_multi_arbiter: RTL and testbench
======================================

// Module: sdram_multi_arbiter
// PURPOSE
//  N-port arbiter in front of the single SDRAM controller port; successor to the fixed 2-port cpu/video arbiter.
//  Selects one requesting port per cycle (fixed-priority or round-robin), forwards its command, and records read ownership in an in-order tag FIFO.
//  Read data is steered back using that FIFO, with a bounded number of outstanding reads.
// PARAMETERS
//  NUM_PORTS        4    number of master ports, 2..8; port 0 is highest fixed priority
//  ADDR_WIDTH       21   word address width
//  DATA_WIDTH       32   data width, multiple of 8
//  MAX_OUTSTANDING  8    ownership FIFO depth (power of 2) = max reads in flight
//  PRIORITY_MODE    0    0 = fixed priority (lowest index wins), 1 = round-robin
// PORTS
//  clk               in   1                      system clock
//  reset             in   1                      synchronous, active-high
//  portChipEnable    in   NUM_PORTS              per-port chip enable
//  portRead          in   NUM_PORTS              per-port read request, held until accepted
//  portWrite         in   NUM_PORTS              per-port write request, held until accepted
//  portBwe           in   NUM_PORTS*DATA_WIDTH/8 per-port byte enables, port i at slice i
//  portAddress       in   NUM_PORTS*ADDR_WIDTH   per-port address, port i at slice i
//  portDataIn        in   NUM_PORTS*DATA_WIDTH   per-port write data
//  portWaitRequest   out  NUM_PORTS              1 = command not accepted this cycle
//  portReadValid     out  NUM_PORTS              one-hot read-data strobe
//  portDataOut       out  DATA_WIDTH             read data, broadcast to all ports
//  sdramChipEnable   out  1                      OR of portChipEnable
//  sdramRead         out  1                      granted read command
//  sdramWrite        out  1                      granted write command
//  sdramBwe          out  DATA_WIDTH/8           granted port's byte enables
//  sdramAddress      out  ADDR_WIDTH             granted port's address
//  sdramDataIn       out  DATA_WIDTH             granted port's write data
//  sdramWaitRequest  in   1                      controller stall
//  sdramReadValid    in   1                      controller read-data strobe, in order
//  sdramDataOut      in   DATA_WIDTH             controller read data
//  outstandingReads  out  $clog2(MAX_OUTSTANDING)+1  reads in flight (FIFO count)
//  protocolError     out  1                      sticky: sdramReadValid seen with FIFO empty
// BEHAVIOUR
//  - Eligible[i] = portWrite[i] | (portRead[i] & !fifoFull). Read+write both set on one port: read takes precedence.
//  - Grant is combinational from Eligible; zero added latency on the command path.
//    - Fixed mode: lowest eligible index wins.
//    - RR mode: first eligible index at or after rrPtr, wrapping NUM_PORTS-1 -> 0.
//  - sdram command outputs carry the granted port's fields. With no grant: sdramRead = sdramWrite = 0; sdramAddress/Bwe/DataIn = port 0 fields.
//  - portWaitRequest[i] = !(grant[i] & !sdramWaitRequest). Ungranted and full-blocked readers therefore see 1.
//  - Accept = a grant exists & !sdramWaitRequest.
//  - On accept of a read: push the granted index. Accept of a write: no push.
//  - RR only: on accept, rrPtr <= grantIdx + 1 (mod NUM_PORTS). rrPtr holds when nothing is accepted.
//  - Read return: on sdramReadValid with FIFO non-empty, portReadValid[head] = 1 and the FIFO pops. Same cycle as sdramReadValid (combinational steer).
//  - Same-cycle push and pop are both performed; count is unchanged.
//  - fifoFull is evaluated before the same-cycle pop, so full blocks reads even if a pop occurs.
//  - sdramReadValid with FIFO empty: no portReadValid, no pop, protocolError <= 1. Cleared only by reset.
//  - Reset (also mid-transfer) clears FIFO, rrPtr, protocolError and outstandingReads to 0.
//    - While reset = 1: sdramRead/sdramWrite = 0, portWaitRequest = all 1, portReadValid = 0.
//    - Reads in flight at reset are discarded: a later sdramReadValid sets protocolError.
// STRUCTURE
//  - sdram_arbiter_pkg: priority_mode_e {PRIO_FIXED, PRIO_RR}; function for index width from NUM_PORTS.
//  - Sub-module sdram_arbiter_owner_fifo: parametrised sync FIFO holding port indices, with count/full/empty outputs.
//  - Grant logic and steering stay in the top module.
// TESTING
//  1. Fixed mode, ports 1 and 3 request reads together, sdramWaitRequest = 0 -> port 1 accepted first, port 3 next cycle; the two sdramReadValid pulses give portReadValid = 4'b0010 then 4'b1000.
//  2. RR mode, all 4 ports hold writes for 8 cycles -> grant order 0,1,2,3,0,1,2,3; outstandingReads stays 0.
//  3. sdramWaitRequest = 1 for 3 cycles under a port 2 read -> port 2 held, one push only, address stable, rrPtr unchanged.
//  4. MAX_OUTSTANDING = 8: issue 8 reads with no returns -> 9th read blocked (waitRequest = 1) while a port 0 write is still accepted; one return -> read accepted.
//  5. Push and pop in the same cycle at count 3 -> count stays 3; head tag routed correctly.
//  6. sdramReadValid with FIFO empty -> protocolError = 1, no portReadValid. Assert reset with 2 reads in flight -> outstandingReads = 0 and protocolError = 0 next cycle.

Source files
------------

// File: rtl/sdram_arbiter_pkg.sv
// rtl/sdram_arbiter_pkg.sv - shared types and helpers for the multi-port SDRAM arbiter
package sdram_arbiter_pkg;

  typedef enum logic {
    PRIO_FIXED = 1'b0,
    PRIO_RR    = 1'b1
  } priority_mode_e;

  // Port-index width; a single-bit index is kept even for degenerate port counts.
  function automatic int idxWidth(input int numPorts);
    return (numPorts > 1) ? $clog2(numPorts) : 1;
  endfunction

endpackage

// File: rtl/sdram_multi_arbiter_if.sv
// rtl/sdram_multi_arbiter_if.sv - bundled master-port and controller-side signals of the arbiter
interface sdram_multi_arbiter_if #(
  parameter int NUM_PORTS  = 4,
  parameter int ADDR_WIDTH = 21,
  parameter int DATA_WIDTH = 32
);
  logic [NUM_PORTS-1:0]              portChipEnable;
  logic [NUM_PORTS-1:0]              portRead;
  logic [NUM_PORTS-1:0]              portWrite;
  logic [NUM_PORTS*DATA_WIDTH/8-1:0] portBwe;
  logic [NUM_PORTS*ADDR_WIDTH-1:0]   portAddress;
  logic [NUM_PORTS*DATA_WIDTH-1:0]   portDataIn;
  logic [NUM_PORTS-1:0]              portWaitRequest;
  logic [NUM_PORTS-1:0]              portReadValid;
  logic [DATA_WIDTH-1:0]             portDataOut;

  logic                              sdramChipEnable;
  logic                              sdramRead;
  logic                              sdramWrite;
  logic [DATA_WIDTH/8-1:0]           sdramBwe;
  logic [ADDR_WIDTH-1:0]             sdramAddress;
  logic [DATA_WIDTH-1:0]             sdramDataIn;
  logic                              sdramWaitRequest;
  logic                              sdramReadValid;
  logic [DATA_WIDTH-1:0]             sdramDataOut;

  modport slave (
    input  portChipEnable, portRead, portWrite, portBwe, portAddress, portDataIn,
    input  sdramWaitRequest, sdramReadValid, sdramDataOut,
    output portWaitRequest, portReadValid, portDataOut,
    output sdramChipEnable, sdramRead, sdramWrite, sdramBwe, sdramAddress, sdramDataIn
  );

  modport master (
    output portChipEnable, portRead, portWrite, portBwe, portAddress, portDataIn,
    output sdramWaitRequest, sdramReadValid, sdramDataOut,
    input  portWaitRequest, portReadValid, portDataOut,
    input  sdramChipEnable, sdramRead, sdramWrite, sdramBwe, sdramAddress, sdramDataIn
  );
endinterface

// File: rtl/sdram_arbiter_owner_fifo.sv
// rtl/sdram_arbiter_owner_fifo.sv - in-order FIFO of port indices that own outstanding reads
module sdram_arbiter_owner_fifo #(
  parameter int WIDTH = 2,
  parameter int DEPTH = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   push,
  input  logic                   pop,
  input  logic [WIDTH-1:0]       pushData,
  output logic [WIDTH-1:0]       headData,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full,
  output logic                   empty
);
  localparam int PW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wrPtr;
  logic [PW-1:0]    rdPtr;
  logic             doPush;
  logic             doPop;

  assign full     = (count == (PW+1)'(DEPTH));
  assign empty    = (count == '0);
  assign doPush   = push & !full;
  assign doPop    = pop & !empty;
  assign headData = mem[rdPtr];

  always_ff @(posedge clk) begin
    if (doPush) mem[wrPtr] <= pushData;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
    end else begin
      if (doPush) wrPtr <= wrPtr + 1'b1;
      if (doPop)  rdPtr <= rdPtr + 1'b1;
      case ({doPush, doPop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end
endmodule

// File: rtl/sdram_multi_arbiter.sv
// rtl/sdram_multi_arbiter.sv - N-port arbiter in front of one SDRAM controller port with in-order read steering
module sdram_multi_arbiter
  import sdram_arbiter_pkg::*;
#(
  parameter int NUM_PORTS       = 4,
  parameter int ADDR_WIDTH      = 21,
  parameter int DATA_WIDTH      = 32,
  parameter int MAX_OUTSTANDING = 8,
  parameter int PRIORITY_MODE   = 0
) (
  input  logic                             clk,
  input  logic                             reset,
  sdram_multi_arbiter_if.slave             bus,
  output logic [$clog2(MAX_OUTSTANDING):0] outstandingReads,
  output logic                             protocolError
);
  localparam int IW = idxWidth(NUM_PORTS);
  localparam int BW = DATA_WIDTH / 8;

  logic [NUM_PORTS-1:0] eligible;
  logic [NUM_PORTS-1:0] grantOneHot;
  logic [IW-1:0]        grantIdx;
  logic [IW-1:0]        candIdx;
  logic [IW-1:0]        rrPtr;
  logic [IW-1:0]        headIdx;
  logic                 grantValid;
  logic                 issueRead;
  logic                 accept;
  logic                 popValid;
  logic                 fifoFull;
  logic                 fifoEmpty;

  // Reset masks every request so nothing is granted or accepted while it is held.
  assign eligible = reset ? '0 : (bus.portWrite | (bus.portRead & {NUM_PORTS{!fifoFull}}));

  always_comb begin
    grantValid = 1'b0;
    grantIdx   = '0;
    candIdx    = '0;
    for (int k = 0; k < NUM_PORTS; k++) begin
      if (PRIORITY_MODE == int'(PRIO_RR)) candIdx = IW'((int'(rrPtr) + k) % NUM_PORTS);
      else                                candIdx = IW'(k);
      if (!grantValid && eligible[candIdx]) begin
        grantValid = 1'b1;
        grantIdx   = candIdx;
      end
    end
  end

  assign grantOneHot = grantValid ? (NUM_PORTS'(1) << grantIdx) : '0;
  assign issueRead   = grantValid & bus.portRead[grantIdx] & !fifoFull;
  assign accept      = grantValid & !bus.sdramWaitRequest;

  assign bus.sdramChipEnable = |bus.portChipEnable;
  assign bus.sdramRead       = issueRead;
  assign bus.sdramWrite      = grantValid & !issueRead;
  assign bus.sdramAddress    = bus.portAddress[int'(grantIdx)*ADDR_WIDTH +: ADDR_WIDTH];
  assign bus.sdramBwe        = bus.portBwe[int'(grantIdx)*BW +: BW];
  assign bus.sdramDataIn     = bus.portDataIn[int'(grantIdx)*DATA_WIDTH +: DATA_WIDTH];
  assign bus.portWaitRequest = ~(grantOneHot & {NUM_PORTS{!bus.sdramWaitRequest}});

  // Returned data is steered in the same cycle from the oldest owner tag.
  assign popValid          = !reset & bus.sdramReadValid & !fifoEmpty;
  assign bus.portReadValid = popValid ? (NUM_PORTS'(1) << headIdx) : '0;
  assign bus.portDataOut   = bus.sdramDataOut;

  sdram_arbiter_owner_fifo #(
    .WIDTH (IW),
    .DEPTH (MAX_OUTSTANDING)
  ) ownerFifo (
    .clk      (clk),
    .reset    (reset),
    .push     (accept & issueRead),
    .pop      (popValid),
    .pushData (grantIdx),
    .headData (headIdx),
    .count    (outstandingReads),
    .full     (fifoFull),
    .empty    (fifoEmpty)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      rrPtr         <= '0;
      protocolError <= 1'b0;
    end else begin
      if (accept && PRIORITY_MODE == int'(PRIO_RR))
        rrPtr <= (grantIdx == IW'(NUM_PORTS-1)) ? '0 : grantIdx + 1'b1;
      if (bus.sdramReadValid && fifoEmpty)
        protocolError <= 1'b1;
    end
  end
endmodule

// File: tb/tb_sdram_multi_arbiter.sv
// tb/tb_sdram_multi_arbiter.sv - directed vector bench for fixed-priority and round-robin arbiter instances
module tb_sdram_multi_arbiter;
  localparam int NP = 4;
  localparam int AW = 21;
  localparam int DW = 32;
  localparam int MO = 8;
  localparam int CW = $clog2(MO) + 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rstF;
  logic          rstR;
  logic [CW-1:0] outF;
  logic [CW-1:0] outR;
  logic          errF;
  logic          errR;
  int            checks   = 0;
  int            failures = 0;

  sdram_multi_arbiter_if #(.NUM_PORTS(NP), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) busF ();
  sdram_multi_arbiter_if #(.NUM_PORTS(NP), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) busR ();

  sdram_multi_arbiter #(.NUM_PORTS(NP), .ADDR_WIDTH(AW), .DATA_WIDTH(DW),
                        .MAX_OUTSTANDING(MO), .PRIORITY_MODE(0)) dutF (
    .clk(clk), .reset(rstF), .bus(busF), .outstandingReads(outF), .protocolError(errF));

  sdram_multi_arbiter #(.NUM_PORTS(NP), .ADDR_WIDTH(AW), .DATA_WIDTH(DW),
                        .MAX_OUTSTANDING(MO), .PRIORITY_MODE(1)) dutR (
    .clk(clk), .reset(rstR), .bus(busR), .outstandingReads(outR), .protocolError(errR));

  typedef struct {
    logic [3:0]  rd;
    logic [3:0]  wr;
    logic        sw;
    logic        srv;
    logic [3:0]  eWait;
    logic [3:0]  eRv;
    logic        eRd;
    logic        eWr;
    logic [20:0] eAddr;
    logic [3:0]  eCnt;
  } vec_t;

  vec_t vecs[13];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic driveF(input logic [3:0] rd, input logic [3:0] wr, input logic sw, input logic srv);
    busF.portRead = rd; busF.portWrite = wr; busF.portChipEnable = rd | wr;
    busF.sdramWaitRequest = sw; busF.sdramReadValid = srv;
  endtask

  task automatic driveR(input logic [3:0] rd, input logic [3:0] wr, input logic sw, input logic srv);
    busR.portRead = rd; busR.portWrite = wr; busR.portChipEnable = rd | wr;
    busR.sdramWaitRequest = sw; busR.sdramReadValid = srv;
  endtask

  initial begin
    logic [3:0] expRv [3];
    expRv[0] = 4'b0010; expRv[1] = 4'b0100; expRv[2] = 4'b1000;

    vecs[0]  = '{4'b0000, 4'b0000, 1'b0, 1'b0, 4'b1111, 4'b0000, 1'b0, 1'b0, 21'h100, 4'd0};
    vecs[1]  = '{4'b1010, 4'b0000, 1'b0, 1'b0, 4'b1101, 4'b0000, 1'b1, 1'b0, 21'h101, 4'd0};
    vecs[2]  = '{4'b1000, 4'b0000, 1'b0, 1'b0, 4'b0111, 4'b0000, 1'b1, 1'b0, 21'h103, 4'd1};
    vecs[3]  = '{4'b0000, 4'b0000, 1'b0, 1'b1, 4'b1111, 4'b0010, 1'b0, 1'b0, 21'h100, 4'd2};
    vecs[4]  = '{4'b0000, 4'b0000, 1'b0, 1'b1, 4'b1111, 4'b1000, 1'b0, 1'b0, 21'h100, 4'd1};
    vecs[5]  = '{4'b0000, 4'b0000, 1'b0, 1'b0, 4'b1111, 4'b0000, 1'b0, 1'b0, 21'h100, 4'd0};
    vecs[6]  = '{4'b0100, 4'b0100, 1'b0, 1'b0, 4'b1011, 4'b0000, 1'b1, 1'b0, 21'h102, 4'd0};
    vecs[7]  = '{4'b0010, 4'b0001, 1'b0, 1'b0, 4'b1110, 4'b0000, 1'b0, 1'b1, 21'h100, 4'd1};
    vecs[8]  = '{4'b0010, 4'b0001, 1'b1, 1'b0, 4'b1111, 4'b0000, 1'b0, 1'b1, 21'h100, 4'd1};
    vecs[9]  = '{4'b0010, 4'b0000, 1'b0, 1'b1, 4'b1101, 4'b0100, 1'b1, 1'b0, 21'h101, 4'd1};
    vecs[10] = '{4'b0000, 4'b0000, 1'b0, 1'b0, 4'b1111, 4'b0000, 1'b0, 1'b0, 21'h100, 4'd1};
    vecs[11] = '{4'b0000, 4'b0000, 1'b0, 1'b1, 4'b1111, 4'b0010, 1'b0, 1'b0, 21'h100, 4'd1};
    vecs[12] = '{4'b0000, 4'b0000, 1'b0, 1'b0, 4'b1111, 4'b0000, 1'b0, 1'b0, 21'h100, 4'd0};

    busF.portAddress  = {21'h103, 21'h102, 21'h101, 21'h100};
    busR.portAddress  = {21'h103, 21'h102, 21'h101, 21'h100};
    busF.portDataIn   = {32'hA000_0003, 32'hA000_0002, 32'hA000_0001, 32'hA000_0000};
    busR.portDataIn   = {32'hA000_0003, 32'hA000_0002, 32'hA000_0001, 32'hA000_0000};
    busF.portBwe      = {4'b1000, 4'b0100, 4'b0010, 4'b0001};
    busR.portBwe      = {4'b1000, 4'b0100, 4'b0010, 4'b0001};
    busF.sdramDataOut = 32'hDEAD_0001;
    busR.sdramDataOut = 32'hBEEF_0002;
    driveF(4'b0000, 4'b0000, 1'b0, 1'b0);
    driveR(4'b0000, 4'b0000, 1'b0, 1'b0);
    rstF = 1'b1;
    rstR = 1'b1;
    tick();
    tick();
    chk("reset.cnt", outF, 0);
    chk("reset.err", errF, 0);
    driveF(4'b1111, 4'b1111, 1'b0, 1'b1);
    #1;
    chk("reset.wait", busF.portWaitRequest, 4'b1111);
    chk("reset.rd", busF.sdramRead, 0);
    chk("reset.wr", busF.sdramWrite, 0);
    chk("reset.rv", busF.portReadValid, 4'b0000);
    driveF(4'b0000, 4'b0000, 1'b0, 1'b0);
    rstF = 1'b0;
    rstR = 1'b0;

    for (int i = 0; i < 13; i++) begin
      tick();
      driveF(vecs[i].rd, vecs[i].wr, vecs[i].sw, vecs[i].srv);
      #1;
      chk($sformatf("vec%0d.wait", i), busF.portWaitRequest, vecs[i].eWait);
      chk($sformatf("vec%0d.rv", i), busF.portReadValid, vecs[i].eRv);
      chk($sformatf("vec%0d.sdramRead", i), busF.sdramRead, vecs[i].eRd);
      chk($sformatf("vec%0d.sdramWrite", i), busF.sdramWrite, vecs[i].eWr);
      chk($sformatf("vec%0d.addr", i), busF.sdramAddress, vecs[i].eAddr);
      chk($sformatf("vec%0d.cnt", i), outF, vecs[i].eCnt);
    end
    chk("fixed.dataOut", busF.portDataOut, 32'hDEAD_0001);

    for (int p = 0; p < 3; p++) begin
      tick();
      driveF(4'(1 << p), 4'b0000, 1'b0, 1'b0);
    end
    tick();
    driveF(4'b1000, 4'b0000, 1'b0, 1'b1);
    #1;
    chk("pushpop.cntBefore", outF, 3);
    chk("pushpop.rv", busF.portReadValid, 4'b0001);
    chk("pushpop.wait", busF.portWaitRequest, 4'b0111);
    tick();
    driveF(4'b0000, 4'b0000, 1'b0, 1'b0);
    #1;
    chk("pushpop.cntAfter", outF, 3);
    for (int j = 0; j < 3; j++) begin
      tick();
      driveF(4'b0000, 4'b0000, 1'b0, 1'b1);
      #1;
      chk($sformatf("pushpop.drain%0d", j), busF.portReadValid, expRv[j]);
    end
    tick();
    driveF(4'b0000, 4'b0000, 1'b0, 1'b0);
    #1;
    chk("pushpop.empty", outF, 0);

    for (int j = 0; j < 8; j++) begin
      tick();
      driveF(4'b0010, 4'b0000, 1'b0, 1'b0);
      #1;
      chk($sformatf("fill%0d.wait", j), busF.portWaitRequest, 4'b1101);
    end
    tick();
    driveF(4'b0010, 4'b0001, 1'b0, 1'b0);
    #1;
    chk("full.cnt", outF, 8);
    chk("full.writeWait", busF.portWaitRequest, 4'b1110);
    chk("full.writeCmd", busF.sdramWrite, 1);
    tick();
    driveF(4'b0010, 4'b0000, 1'b0, 1'b0);
    #1;
    chk("full.readBlocked", busF.portWaitRequest, 4'b1111);
    chk("full.noRead", busF.sdramRead, 0);
    tick();
    driveF(4'b0010, 4'b0000, 1'b0, 1'b1);
    #1;
    chk("full.popRv", busF.portReadValid, 4'b0010);
    chk("full.blockedDuringPop", busF.portWaitRequest, 4'b1111);
    tick();
    driveF(4'b0010, 4'b0000, 1'b0, 1'b0);
    #1;
    chk("full.cnt7", outF, 7);
    chk("full.readAccepted", busF.portWaitRequest, 4'b1101);
    chk("full.readCmd", busF.sdramRead, 1);
    for (int j = 0; j < 8; j++) begin
      tick();
      driveF(4'b0000, 4'b0000, 1'b0, 1'b1);
      #1;
      chk($sformatf("full.drain%0d", j), busF.portReadValid, 4'b0010);
    end
    tick();
    driveF(4'b0000, 4'b0000, 1'b0, 1'b0);
    #1;
    chk("full.drained", outF, 0);

    tick();
    driveF(4'b0000, 4'b0000, 1'b0, 1'b1);
    #1;
    chk("perr.noRv", busF.portReadValid, 4'b0000);
    chk("perr.notYet", errF, 0);
    tick();
    driveF(4'b0001, 4'b0000, 1'b0, 1'b0);
    #1;
    chk("perr.set", errF, 1);
    tick();
    tick();
    driveF(4'b1111, 4'b0000, 1'b0, 1'b1);
    rstF = 1'b1;
    #1;
    chk("midreset.cntBefore", outF, 2);
    chk("midreset.wait", busF.portWaitRequest, 4'b1111);
    chk("midreset.rd", busF.sdramRead, 0);
    chk("midreset.rv", busF.portReadValid, 4'b0000);
    tick();
    rstF = 1'b0;
    driveF(4'b0000, 4'b0000, 1'b0, 1'b1);
    #1;
    chk("midreset.cnt", outF, 0);
    chk("midreset.err", errF, 0);
    chk("midreset.staleRv", busF.portReadValid, 4'b0000);
    tick();
    driveF(4'b0000, 4'b0000, 1'b0, 1'b0);
    #1;
    chk("midreset.staleErr", errF, 1);

    for (int k = 0; k < 8; k++) begin
      tick();
      driveR(4'b0000, 4'b1111, 1'b0, 1'b0);
      #1;
      chk($sformatf("rr%0d.wait", k), busR.portWaitRequest, 4'b1111 ^ (4'b0001 << (k % 4)));
      chk($sformatf("rr%0d.bwe", k), busR.sdramBwe, 4'b0001 << (k % 4));
      chk($sformatf("rr%0d.data", k), busR.sdramDataIn, 32'hA000_0000 + 32'(k % 4));
      chk($sformatf("rr%0d.cnt", k), outR, 0);
    end
    chk("rr.chipEnable", busR.sdramChipEnable, 1);

    for (int k = 0; k < 3; k++) begin
      tick();
      driveR(4'b0100, 4'b0000, 1'b1, 1'b0);
      #1;
      chk($sformatf("stall%0d.wait", k), busR.portWaitRequest, 4'b1111);
      chk($sformatf("stall%0d.addr", k), busR.sdramAddress, 21'h102);
      chk($sformatf("stall%0d.rd", k), busR.sdramRead, 1);
      chk($sformatf("stall%0d.cnt", k), outR, 0);
    end
    tick();
    driveR(4'b0100, 4'b1011, 1'b1, 1'b0);
    #1;
    chk("stall.ptrHeld.wr", busR.sdramWrite, 1);
    chk("stall.ptrHeld.addr", busR.sdramAddress, 21'h100);
    tick();
    driveR(4'b0100, 4'b0000, 1'b0, 1'b0);
    #1;
    chk("stall.release.wait", busR.portWaitRequest, 4'b1011);
    tick();
    driveR(4'b0000, 4'b0000, 1'b0, 1'b0);
    #1;
    chk("stall.onePush", outR, 1);
    tick();
    driveR(4'b0000, 4'b0000, 1'b0, 1'b1);
    #1;
    chk("stall.rv", busR.portReadValid, 4'b0100);
    chk("stall.dataOut", busR.portDataOut, 32'hBEEF_0002);
    tick();
    driveR(4'b0000, 4'b1111, 1'b0, 1'b0);
    #1;
    chk("stall.drained", outR, 0);
    chk("rr.afterPort2", busR.portWaitRequest, 4'b0111);
    chk("rr.noErr", errR, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
